// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NCH-input, WIDTH-bit registered mux with per-channel valid/ready.
// A round-robin or fixed-priority arbiter picks one requester per transfer, and
// the winning beat lands in a one-entry output register tagged with its channel.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   mode             0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid/in_ready per-channel handshake, in_data packed [i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data/out_ch  registered output beat and its source
// Optional macro RR_MUX_LOCK_EN adds in_last/out_last: a burst locks the grant
// to its channel until the beat flagged last has been accepted.
module rr_mux_reg #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic [SELW-1:0]  r_rr_ptr;
`ifdef RR_MUX_LOCK_EN
    logic             r_lock;
    logic [SELW-1:0]  r_lock_ch;
    logic             r_last;
`endif

    logic             w_load_en;
    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_sel;
    logic [SELW-1:0]  w_idx;
    logic             w_found;
    logic [WIDTH-1:0] w_data;
    logic             w_xfer;

    // The register can take a new beat when empty or being drained this cycle.
    assign w_load_en = !r_valid || out_ready;

    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (w_load_en) begin
`ifdef RR_MUX_LOCK_EN
            // A locked channel owns the output even while it idles.
            if (r_lock) begin
                if (in_valid[r_lock_ch]) begin
                    w_grant[r_lock_ch] = 1'b1;
                    w_sel              = r_lock_ch;
                end
            end else
`endif
            if (mode) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!w_found && in_valid[i]) begin
                        w_found    = 1'b1;
                        w_grant[i] = 1'b1;
                        w_sel      = SELW'(i);
                    end
                end
            end else begin
                // Search starts just after the last round-robin winner.
                for (int k = 1; k <= NCH; k++) begin
                    w_idx = SELW'((int'(r_rr_ptr) + k) % NCH);
                    if (!w_found && in_valid[w_idx]) begin
                        w_found        = 1'b1;
                        w_grant[w_idx] = 1'b1;
                        w_sel          = w_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants only go to requesters, so any grant is a transfer.
    assign w_xfer   = |w_grant;
    assign in_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ch      <= '0;
            r_rr_ptr  <= SELW'(NCH - 1);
`ifdef RR_MUX_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            r_last    <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_ch    <= w_sel;
`ifdef RR_MUX_LOCK_EN
            r_last  <= in_last[w_sel];
            if (!in_last[w_sel]) begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_sel;
            end else begin
                r_lock <= 1'b0;
                if (!mode) begin
                    r_rr_ptr <= w_sel;
                end
            end
`else
            if (!mode) begin
                r_rr_ptr <= w_sel;
            end
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;
`ifdef RR_MUX_LOCK_EN
    assign out_last  = r_last;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: self-checking bench for rr_mux_reg with a behavioural model,
// directed scenarios with literal expectations, and randomized traffic.
module tb_rr_mux_reg;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 mode      = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NCH-1:0]       in_valid  = '0;
    logic [NCH*WIDTH-1:0] in_data   = '0;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
`ifdef RR_MUX_LOCK_EN
    logic [NCH-1:0]       in_last   = '1;
    logic                 out_last;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Model state: what the output register must hold, plus arbitration state.
    logic             m_valid   = 1'b0;
    logic [WIDTH-1:0] m_data    = '0;
    int               m_ch      = 0;
    int               m_ptr     = NCH - 1;
    logic             m_lock    = 1'b0;
    int               m_lock_ch = 0;
    logic             m_last    = 1'b0;

    localparam logic [NCH*WIDTH-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    always #5 clk = ~clk;

    rr_mux_reg #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Which channel the spec rules say wins this cycle, or -1 for none.
    function automatic int pick();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode) begin
            for (int i = 0; i < NCH; i++)
                if (in_valid[i]) return i;
        end else begin
            for (int k = 1; k <= NCH; k++)
                if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ch      <= 0;
            m_ptr     <= NCH - 1;
            m_lock    <= 1'b0;
            m_lock_ch <= 0;
            m_last    <= 1'b0;
        end else if (pick() >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[pick()*WIDTH +: WIDTH];
            m_ch    <= pick();
`ifdef RR_MUX_LOCK_EN
            m_last <= in_last[pick()];
            if (!in_last[pick()]) begin
                m_lock    <= 1'b1;
                m_lock_ch <= pick();
            end else begin
                m_lock <= 1'b0;
                if (!mode) m_ptr <= pick();
            end
`else
            if (!mode) m_ptr <= pick();
`endif
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (pick() >= 0) ? (32'd1 << pick()) : 32'd0);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_ch", out_ch, m_ch);
`ifdef RR_MUX_LOCK_EN
        chk("out_last", out_last, m_last);
`endif
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid  = '1;
        in_data   = DATA_A;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        adv();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", in_ready, 4'b0001);
        adv();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_ch", out_ch, i % 4);
            chk("rr_data", out_data, 8'hA0 + i % 4);
            chk("rr_valid", out_valid, 1);
            adv();
        end

        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("fp_ready", in_ready, 4'b0010);
            if (j > 0) chk("fp_ch", out_ch, 1);
            adv();
        end
        in_valid = 4'b1000;
        @(negedge clk);
        chk("fp_ch_hold", out_ch, 1);
        chk("fp_ready3", in_ready, 4'b1000);
        adv();
        @(negedge clk);
        chk("fp_ch3", out_ch, 3);
        adv();

        mode            = 1'b0;
        in_valid        = 4'b0100;
        in_data[23:16]  = 8'h5C;
        @(negedge clk);
        chk("bp_grant2", in_ready, 4'b0100);
        adv();
        in_valid  = '1;
        in_data   = DATA_A;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_ch", out_ch, 2);
            chk("bp_data", out_data, 8'h5C);
            chk("bp_ready", in_ready, 0);
            adv();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", in_ready, 4'b1000);
        adv();
        @(negedge clk);
        chk("bp_next_ch", out_ch, 3);
        chk("bp_next_data", out_data, 8'hA3);
        adv();

        in_valid = '0;
        adv();
        in_valid = 4'b1000;
        @(negedge clk);
        chk("sp_ready", in_ready, 4'b1000);
        adv();
        in_valid = '0;
        @(negedge clk);
        chk("sp_valid", out_valid, 1);
        chk("sp_ch", out_ch, 3);
        adv();
        @(negedge clk);
        chk("sp_drain", out_valid, 0);
        chk("sp_ch_hold", out_ch, 3);
        adv();
        in_valid = 4'b0001;
        @(negedge clk);
        chk("sp_wrap", in_ready, 4'b0001);
        adv();
        @(negedge clk);
        chk("sp_wrap_ch", out_ch, 0);
        adv();

        for (int n = 0; n < 600; n++) begin
            if ($urandom % 16 == 0) mode = ~mode;
            in_valid  = NCH'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom % 4) != 0;
`ifdef RR_MUX_LOCK_EN
            for (int c = 0; c < NCH; c++) in_last[c] = ($urandom % 3) != 0;
`endif
            if (n == 300) rst_n = 1'b0;
            if (n == 302) rst_n = 1'b1;
            adv();
        end

`ifdef RR_MUX_LOCK_EN
        rst_n    = 1'b0;
        in_valid = '0;
        adv();
        rst_n     = 1'b1;
        mode      = 1'b0;
        in_data   = DATA_A;
        out_ready = 1'b1;
        in_last   = '0;
        in_valid  = 4'b0010;
        @(negedge clk);
        chk("lk_first", in_ready, 4'b0010);
        adv();
        in_valid = 4'b0011;
        @(negedge clk);
        chk("lk_held", in_ready, 4'b0010);
        chk("lk_ch_a", out_ch, 1);
        adv();
        in_last = 4'b0010;
        @(negedge clk);
        chk("lk_held2", in_ready, 4'b0010);
        chk("lk_ch_b", out_ch, 1);
        adv();
        in_valid = 4'b0001;
        in_last  = '1;
        @(negedge clk);
        chk("lk_release", in_ready, 4'b0001);
        chk("lk_ch_c", out_ch, 1);
        chk("lk_last", out_last, 1);
        adv();
        @(negedge clk);
        chk("lk_ch0", out_ch, 0);
        adv();
        in_valid = 4'b0010;
        in_last  = '0;
        adv();
        rst_n = 1'b0;
        #1;
        chk("lk_rst_async", out_valid, 0);
        adv();
        rst_n    = 1'b1;
        in_valid = 4'b0001;
        @(negedge clk);
        chk("lk_cleared", in_ready, 4'b0001);
        adv();
        @(negedge clk);
        chk("lk_after_rst", out_ch, 0);
        adv();
`endif

        adv();
        adv();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
